// File: rtl/jellyvl_etherneco_pkg.sv
// ============================================================================
// Module : jellyvl_etherneco_pkg
// Brief  : Shared EtherNeco frame definitions (rx and tx side).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jellyvl_etherneco_pkg;

  // One-hot receive/transmit state encoding
  typedef enum logic [7:0] {
    IDLE     = 8'b0000_0001,
    PREAMBLE = 8'b0000_0010,
    LENGTH   = 8'b0000_0100,
    TYPE     = 8'b0000_1000,
    NODE     = 8'b0001_0000,
    PAYLOAD  = 8'b0010_0000,
    FCS      = 8'b0100_0000,
    ERROR    = 8'b1000_0000
  } state_t;

  localparam int          c_data_width   = 8;
  localparam int          c_length_width = 16;
  localparam int          c_type_width   = 8;
  localparam int          c_node_width   = 8;
  localparam int          c_preamble_len = 8;
  localparam int          c_fcs_bytes    = 4;
  localparam logic [7:0]  c_preamble_byte = 8'h55;
  localparam logic [7:0]  c_sfd_byte      = 8'hD5;
  localparam logic [31:0] c_crc_poly      = 32'h04C11DB7;

  // The FCS protects everything from the first length byte to the last payload byte
  function automatic logic is_crc_state(input state_t s);
    return s inside {LENGTH, TYPE, NODE, PAYLOAD};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jelly2_calc_crc.sv
// ============================================================================
// Module : jelly2_calc_crc
// Brief  : Bytewise CRC engine; init all-ones, output inverted, MSB-first unless REVERSED.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jelly2_calc_crc #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLY_REPS  = CRC_WIDTH'(32'h04C11DB7),
  parameter bit                   REVERSED   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cke_i,
  input  logic                  update_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [CRC_WIDTH-1:0]  crc_o
);

  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_d;

  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] crc,
                                                     input logic [DATA_WIDTH-1:0] data);
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb = c[CRC_WIDTH-1] ^ (REVERSED ? data[i] : data[DATA_WIDTH-1-i]);
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY_REPS : '0);
    end
    return c;
  endfunction

  // update_i=0 restarts the checksum with this byte as the first one
  always_comb begin
    crc_d = crc_q;
    if (cke_i && valid_i) begin
      crc_d = crc_step(update_i ? crc_q : '1, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '1;
    end else begin
      crc_q <= crc_d;
    end
  end

  generate
    if (REVERSED) begin : g_reversed
      always_comb begin
        for (int i = 0; i < CRC_WIDTH; i++) begin
          crc_o[i] = ~crc_q[CRC_WIDTH-1-i];
        end
      end
    end else begin : g_normal
      assign crc_o = ~crc_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/jellyvl_etherneco_packet_rx.sv
// ============================================================================
// Module : jellyvl_etherneco_packet_rx
// Brief  : EtherNeco frame receiver: header decode, payload stream, FCS check.
//          Define JELLYVL_ETHERNECO_RX_PREAMBLE_CHECK_EN to verify preamble/SFD content.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jellyvl_etherneco_packet_rx
  import jellyvl_etherneco_pkg::*;
#(
  parameter bit NODE_CHECK = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [c_node_width-1:0]   my_node,
  input  logic                      s_rx_first,
  input  logic                      s_rx_last,
  input  logic [c_data_width-1:0]   s_rx_data,
  input  logic                      s_rx_valid,
  output logic                      rx_start,
  output logic                      rx_end,
  output logic                      rx_error,
  output logic                      rx_drop,
  output logic [c_length_width-1:0] rx_length,
  output logic [c_type_width-1:0]   rx_type,
  output logic [c_node_width-1:0]   rx_node,
  output logic                      m_payload_first,
  output logic                      m_payload_last,
  output logic [c_data_width-1:0]   m_payload_data,
  output logic                      m_payload_valid
);

  localparam logic [15:0] c_pre_last = 16'(c_preamble_len - 1);
  localparam logic [15:0] c_fcs_last = 16'(c_fcs_bytes - 1);

  state_t                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [c_length_width-1:0] len_q, len_d;
  logic [c_type_width-1:0]   type_q, type_d;
  logic [23:0]               fcs_q, fcs_d;
  logic                      drop_q, drop_d;
  logic [c_length_width-1:0] rx_length_q, rx_length_d;
  logic [c_type_width-1:0]   rx_type_q, rx_type_d;
  logic [c_node_width-1:0]   rx_node_q, rx_node_d;
  logic                      rx_start_q, rx_start_d;
  logic                      rx_end_q, rx_end_d;
  logic                      rx_error_q, rx_error_d;
  logic                      rx_drop_q, rx_drop_d;
  logic                      pay_first_q, pay_first_d;
  logic                      pay_last_q, pay_last_d;
  logic [c_data_width-1:0]   pay_data_q, pay_data_d;
  logic                      pay_valid_q, pay_valid_d;

  logic        crc_valid;
  logic        crc_update;
  logic [31:0] crc_value;
  logic        crc_mismatch;
  logic        preamble_bad;

`ifdef JELLYVL_ETHERNECO_RX_PREAMBLE_CHECK_EN
  logic [7:0] pre_expect;
  always_comb begin
    pre_expect   = (!s_rx_first && state_q == PREAMBLE && cnt_q == c_pre_last) ? c_sfd_byte : c_preamble_byte;
    preamble_bad = (s_rx_data != pre_expect);
  end
`else
  assign preamble_bad = 1'b0;
`endif

  assign crc_valid    = s_rx_valid && !s_rx_first && is_crc_state(state_q);
  assign crc_update   = !(state_q == LENGTH && cnt_q == 16'd0);
  assign crc_mismatch = ({s_rx_data, fcs_q} != crc_value);

  jelly2_calc_crc #(
    .DATA_WIDTH (c_data_width),
    .CRC_WIDTH  (32),
    .POLY_REPS  (c_crc_poly),
    .REVERSED   (1'b0)
  ) u_crc (
    .clk      (clk),
    .rst      (~rst),
    .cke_i    (1'b1),
    .update_i (crc_update),
    .data_i   (s_rx_data),
    .valid_i  (crc_valid),
    .crc_o    (crc_value)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    type_d      = type_q;
    fcs_d       = fcs_q;
    drop_d      = drop_q;
    rx_length_d = rx_length_q;
    rx_type_d   = rx_type_q;
    rx_node_d   = rx_node_q;
    rx_start_d  = 1'b0;
    rx_end_d    = 1'b0;
    rx_error_d  = 1'b0;
    rx_drop_d   = 1'b0;
    pay_valid_d = 1'b0;
    pay_first_d = 1'b0;
    pay_last_d  = 1'b0;
    pay_data_d  = pay_data_q;

    if (s_rx_valid) begin
      if (s_rx_first) begin
        // A new frame start pre-empts whatever was in progress
        if (state_q != IDLE && state_q != ERROR) begin
          rx_end_d   = 1'b1;
          rx_error_d = 1'b1;
          rx_drop_d  = drop_q;
        end
        drop_d = 1'b0;
        if (preamble_bad) begin
          state_d    = ERROR;
          rx_end_d   = 1'b1;
          rx_error_d = 1'b1;
        end else begin
          state_d = PREAMBLE;
          cnt_d   = 16'd1;
        end
      end else if (state_q == IDLE) begin
        state_d = IDLE;
      end else if (state_q == ERROR) begin
        if (s_rx_last) state_d = IDLE;
      end else if (s_rx_last && !(state_q == FCS && cnt_q == c_fcs_last)) begin
        state_d    = IDLE;
        rx_end_d   = 1'b1;
        rx_error_d = 1'b1;
        rx_drop_d  = drop_q;
      end else begin
        unique case (state_q)
          PREAMBLE: begin
            if (preamble_bad) begin
              state_d    = ERROR;
              rx_end_d   = 1'b1;
              rx_error_d = 1'b1;
            end else if (cnt_q == c_pre_last) begin
              state_d = LENGTH;
              cnt_d   = 16'd0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          LENGTH: begin
            if (cnt_q == 16'd0) begin
              len_d[7:0] = s_rx_data;
              cnt_d      = 16'd1;
            end else begin
              len_d[15:8] = s_rx_data;
              cnt_d       = 16'd0;
              state_d     = TYPE;
            end
          end
          TYPE: begin
            type_d  = s_rx_data;
            state_d = NODE;
          end
          NODE: begin
            if (NODE_CHECK && (s_rx_data != my_node)) begin
              drop_d = 1'b1;
            end else begin
              rx_start_d  = 1'b1;
              rx_length_d = len_q;
              rx_type_d   = type_q;
              rx_node_d   = s_rx_data;
            end
            state_d = PAYLOAD;
            cnt_d   = 16'd0;
          end
          PAYLOAD: begin
            if (!drop_q) begin
              pay_valid_d = 1'b1;
              pay_first_d = (cnt_q == 16'd0);
              pay_last_d  = (cnt_q == len_q);
              pay_data_d  = s_rx_data;
            end
            if (cnt_q == len_q) begin
              state_d = FCS;
              cnt_d   = 16'd0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          FCS: begin
            if (cnt_q == c_fcs_last) begin
              rx_end_d  = 1'b1;
              rx_drop_d = drop_q;
              cnt_d     = 16'd0;
              if (s_rx_last) begin
                state_d    = IDLE;
                rx_error_d = !drop_q && crc_mismatch;
              end else begin
                state_d    = ERROR;
                rx_error_d = 1'b1;
              end
            end else begin
              unique case (cnt_q[1:0])
                2'd0:    fcs_d[7:0]   = s_rx_data;
                2'd1:    fcs_d[15:8]  = s_rx_data;
                default: fcs_d[23:16] = s_rx_data;
              endcase
              cnt_d = cnt_q + 16'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      len_q       <= '0;
      type_q      <= '0;
      fcs_q       <= '0;
      drop_q      <= 1'b0;
      rx_length_q <= '0;
      rx_type_q   <= '0;
      rx_node_q   <= '0;
      rx_start_q  <= 1'b0;
      rx_end_q    <= 1'b0;
      rx_error_q  <= 1'b0;
      rx_drop_q   <= 1'b0;
      pay_first_q <= 1'b0;
      pay_last_q  <= 1'b0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      type_q      <= type_d;
      fcs_q       <= fcs_d;
      drop_q      <= drop_d;
      rx_length_q <= rx_length_d;
      rx_type_q   <= rx_type_d;
      rx_node_q   <= rx_node_d;
      rx_start_q  <= rx_start_d;
      rx_end_q    <= rx_end_d;
      rx_error_q  <= rx_error_d;
      rx_drop_q   <= rx_drop_d;
      pay_first_q <= pay_first_d;
      pay_last_q  <= pay_last_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
    end
  end

  assign rx_start        = rx_start_q;
  assign rx_end          = rx_end_q;
  assign rx_error        = rx_error_q;
  assign rx_drop         = rx_drop_q;
  assign rx_length       = rx_length_q;
  assign rx_type         = rx_type_q;
  assign rx_node         = rx_node_q;
  assign m_payload_first = pay_first_q;
  assign m_payload_last  = pay_last_q;
  assign m_payload_data  = pay_data_q;
  assign m_payload_valid = pay_valid_q;

endmodule

`default_nettype wire

// File: doc/jellyvl_etherneco_packet_rx.md
JELLYVL_ETHERNECO_PACKET_RX -- requirements
Module: jellyvl_etherneco_packet_rx

Interface
REQ-001 SHALL have parameter NODE_CHECK, default 0; when 1, frames whose node byte differs from input my_node are dropped (no payload output, rx_end with rx_error=0, rx_drop=1).
REQ-002 SHALL have ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-low reset.
- my_node  input  8  local node id (used when NODE_CHECK=1).
- s_rx_first  input  1  marks the first preamble byte.
- s_rx_last  input  1  marks the final byte (last FCS byte, or abort marker).
- s_rx_data  input  8  received byte.
- s_rx_valid  input  1  byte strobe; no ready, receiver always accepts.
- rx_start  output  1  one-cycle pulse: header accepted.
- rx_end  output  1  one-cycle pulse: frame finished.
- rx_error  output  1  qualifies rx_end: CRC/format/abort error.
- rx_drop  output  1  qualifies rx_end: node mismatch.
- rx_length  output  16  latched length field (payload bytes minus 1).
- rx_type  output  8  latched type byte.
- rx_node  output  8  latched node byte.
- m_payload_first  output  1  first payload byte.
- m_payload_last  output  1  final payload byte (length-counted).
- m_payload_data  output  8  payload byte.
- m_payload_valid  output  1  payload strobe; no ready.

Function
REQ-003 Frame format SHALL be: 7x 0x55, 0xD5, length[7:0], length[15:8], type, node, length+1 payload bytes, 4 FCS bytes LSB first.
REQ-004 State machine SHALL have states IDLE, PREAMBLE, LENGTH, TYPE, NODE, PAYLOAD, FCS, ERROR; advances only on s_rx_valid.
REQ-005 IDLE->PREAMBLE on valid&&first; PREAMBLE counts 8 bytes then ->LENGTH; LENGTH 2 bytes ->TYPE ->NODE ->PAYLOAD; PAYLOAD counts length+1 bytes ->FCS; FCS 4 bytes ->IDLE.
REQ-006 s_rx_first in any non-IDLE state SHALL abort current frame (rx_end, rx_error=1) and restart PREAMBLE with that byte as preamble byte 0.
REQ-007 s_rx_last before the 4th FCS byte SHALL go to IDLE with rx_end=1, rx_error=1; missing s_rx_last on 4th FCS byte SHALL give rx_error=1 and enter ERROR, which waits for valid&&last then ->IDLE without further rx_end.
REQ-008 CRC-32 (poly 0x04C11DB7, non-reflected, jelly2_calc_crc semantics identical to the transmitter) SHALL cover length..last payload byte; restart on first length byte.
REQ-009 The received FCS, assembled LSB first, SHALL be compared with the computed CRC; mismatch sets rx_error on rx_end.
REQ-010 rx_start SHALL pulse the cycle after the node byte is received (and matches, if NODE_CHECK=1); rx_length/type/node stable from then until the next rx_start.
REQ-011 Payload outputs SHALL lag s_rx_data by exactly 1 cycle; m_payload_first on payload byte 0, m_payload_last on byte length (counter 16-bit, length 0xFFFF gives 65536 bytes).
REQ-012 rx_end SHALL pulse 1 cycle after the last FCS byte; rx_error/rx_drop valid only when rx_end=1, else 0.
REQ-013 Bytes with s_rx_valid=0 SHALL not change state, counters or CRC; gaps allowed anywhere.

Reset
REQ-014 While rst=0 at a clk edge: state IDLE, all pulse/valid outputs 0, rx_length/type/node 0, counters 0; reset mid-frame discards the frame with no rx_end.

Configuration
REQ-015 With JELLYVL_ETHERNECO_RX_PREAMBLE_CHECK_EN defined, preamble bytes 0..6 SHALL equal 0x55 and byte 7 0xD5, else ->ERROR with rx_end, rx_error=1; without it preamble content is ignored, only counted.

Structure
REQ-016 State enum (one-hot, 8-bit), preamble/SFD constants, frame field widths SHALL live in package jellyvl_etherneco_pkg, shared with the transmitter.
REQ-017 CRC SHALL be a jelly2_calc_crc instance (DATA_WIDTH 8, CRC_WIDTH 32, REVERSED 0); no other sub-module.

Verification
REQ-018 Loopback from packet transmitter, length=3, type=0x12, node=0x34, payload 01 02 03 04 -> rx_start, payload 01..04 with first/last, rx_end, rx_error=0, rx_length=3.
REQ-019 Same frame with one payload bit flipped -> payload delivered, rx_end with rx_error=1.
REQ-020 Transmitter cancel mid-payload (last=1, data 0x00) -> rx_end, rx_error=1, IDLE; next good frame received cleanly.
REQ-021 NODE_CHECK=1, my_node=0x05, frame node 0x06 -> no rx_start, no payload, rx_end with rx_drop=1.
REQ-022 Random s_rx_valid gaps (50%) over length=0 and length=255 frames -> 1 and 256 payload bytes, rx_error=0.
REQ-023 With PREAMBLE_CHECK_EN, preamble byte 3 = 0x54 -> rx_end, rx_error=1, no rx_start; without it, frame accepted.
